// File: rtl/video_mode_ctrl_if.sv
// Request/status and generator-side bus of the video mode controller.
// The slave modport is the controller and the master modport is whatever drives it.
interface video_mode_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_mode;
  logic        req_ready;
  logic        done;
  logic        err;
  logic        busy;
  logic [2:0]  cur_mode;
  logic        vs_in;
  logic        vg_reset;
  logic [1:0]  clk_sel;
  logic        interlaced;
  logic [11:0] h_total;
  logic [11:0] h_fp;
  logic [11:0] h_sync;
  logic [11:0] h_bp;
  logic [11:0] v_total_0;
  logic [11:0] v_fp_0;
  logic [11:0] v_sync_0;
  logic [11:0] v_bp_0;
  logic [11:0] v_total_1;
  logic [11:0] v_fp_1;
  logic [11:0] v_sync_1;
  logic [11:0] v_bp_1;
  logic [11:0] hv_offset_1;
  logic [19:0] ramp_step;

  modport master (
    output req_valid, req_mode, vs_in,
    input  req_ready, done, err, busy, cur_mode, vg_reset, clk_sel, interlaced,
           h_total, h_fp, h_sync, h_bp, v_total_0, v_fp_0, v_sync_0, v_bp_0,
           v_total_1, v_fp_1, v_sync_1, v_bp_1, hv_offset_1, ramp_step
  );

  modport slave (
    input  req_valid, req_mode, vs_in,
    output req_ready, done, err, busy, cur_mode, vg_reset, clk_sel, interlaced,
           h_total, h_fp, h_sync, h_bp, v_total_0, v_fp_0, v_sync_0, v_bp_0,
           v_total_1, v_fp_1, v_sync_1, v_bp_1, hv_offset_1, ramp_step
  );
endinterface

// File: rtl/video_mode_ctrl.sv
// Sequences video mode changes on a vsync boundary, holding the generator in reset across
// the pixel-clock switch. Optional macro VMC_TIMEOUT_EN adds a stall timeout in WAIT_VS/LOCK.
module video_mode_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 256,
  parameter int unsigned LOCK_FRAMES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4000000,
  parameter logic [2:0]  DEFAULT_MODE   = 3'd2
) (
  input logic              clk,
  input logic              reset,
  video_mode_ctrl_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int LW = $clog2(LOCK_FRAMES) + 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_FRAMES - 1);

  if (SETTLE_CYCLES < 2) begin : g_chk_settle
    $error("SETTLE_CYCLES must be at least 2");
  end
  if (LOCK_FRAMES < 1) begin : g_chk_lock
    $error("LOCK_FRAMES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32'd8388607) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must fit the 23-bit timeout counter");
  end
  if (DEFAULT_MODE > 3'd4) begin : g_chk_default
    $error("DEFAULT_MODE must be a valid mode code");
  end

  typedef enum logic [2:0] {IDLE, WAIT_VS, HOLD, SETTLE, LOCK} state_t;

  typedef struct packed {
    logic [1:0]  clk_sel;
    logic        interlaced;
    logic [11:0] h_total, h_fp, h_sync, h_bp;
    logic [11:0] v_total_0, v_fp_0, v_sync_0, v_bp_0;
    logic [11:0] v_total_1, v_fp_1, v_sync_1, v_bp_1;
    logic [11:0] hv_offset_1;
    logic [19:0] ramp_step;
  } timing_t;

  function automatic timing_t mode_entry(input logic [2:0] mode);
    timing_t t;
    t = '0;
    case (mode)
      3'd0: begin
        t.h_total = 12'd1716; t.h_fp = 12'd110; t.h_sync = 12'd40; t.h_bp = 12'd220;
        t.v_total_0 = 12'd262; t.v_fp_0 = 12'd5; t.v_sync_0 = 12'd5; t.v_bp_0 = 12'd20;
        t.clk_sel = 2'd0; t.ramp_step = 20'h00333;
      end
      3'd1: begin
        t.h_total = 12'd858; t.h_fp = 12'd16; t.h_sync = 12'd62; t.h_bp = 12'd60;
        t.v_total_0 = 12'd525; t.v_fp_0 = 12'd9; t.v_sync_0 = 12'd6; t.v_bp_0 = 12'd30;
        t.clk_sel = 2'd0; t.ramp_step = 20'h00333;
      end
      3'd2: begin
        t.h_total = 12'd1650; t.h_fp = 12'd110; t.h_sync = 12'd40; t.h_bp = 12'd220;
        t.v_total_0 = 12'd750; t.v_fp_0 = 12'd5; t.v_sync_0 = 12'd5; t.v_bp_0 = 12'd20;
        t.clk_sel = 2'd1; t.ramp_step = 20'h00333;
      end
      3'd3: begin
        t.h_total = 12'd2200; t.h_fp = 12'd88; t.h_sync = 12'd44; t.h_bp = 12'd148;
        t.v_total_0 = 12'd562; t.v_fp_0 = 12'd2; t.v_sync_0 = 12'd5; t.v_bp_0 = 12'd15;
        t.v_total_1 = 12'd563; t.v_fp_1 = 12'd2; t.v_sync_1 = 12'd5; t.v_bp_1 = 12'd16;
        t.interlaced = 1'b1; t.hv_offset_1 = 12'd1100;
        t.clk_sel = 2'd1; t.ramp_step = 20'h00222;
      end
      3'd4: begin
        t.h_total = 12'd2200; t.h_fp = 12'd88; t.h_sync = 12'd44; t.h_bp = 12'd148;
        t.v_total_0 = 12'd1125; t.v_fp_0 = 12'd4; t.v_sync_0 = 12'd5; t.v_bp_0 = 12'd36;
        t.clk_sel = 2'd2; t.ramp_step = 20'h00222;
      end
      default: t = '0;
    endcase
    return t;
  endfunction

  state_t        state_q, state_d;
  timing_t       timing_q, timing_d;
  logic [2:0]    cur_mode_q, cur_mode_d;
  logic [2:0]    pend_mode_q, pend_mode_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [2:0]    vs_sync_q, vs_sync_d;
  logic          vs_rise_q, vs_rise_d;
  logic          vg_reset_q, vg_reset_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tmo_hit;

`ifdef VMC_TIMEOUT_EN
  localparam logic [22:0] TMO_LAST = 23'(TIMEOUT_CYCLES - 1);
  logic [22:0] tmo_cnt_q, tmo_cnt_d;
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
  // Free-running only while waiting on the generator; any other state parks it at zero.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == WAIT_VS || state_q == LOCK) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    timing_d     = timing_q;
    cur_mode_d   = cur_mode_q;
    pend_mode_d  = pend_mode_q;
    settle_cnt_d = settle_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    vg_reset_d   = vg_reset_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    vs_sync_d    = {vs_sync_q[1:0], bus.vs_in};
    vs_rise_d    = vs_sync_q[1] & ~vs_sync_q[2];

    case (state_q)
      IDLE: begin
        // vg_reset can only be high in IDLE during the post-reset settle period.
        if (vg_reset_q) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            vg_reset_d   = 1'b0;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        if (bus.req_valid && req_ready_q) begin
          if (bus.req_mode > 3'd4) begin
            err_d = 1'b1;
          end else begin
            pend_mode_d = bus.req_mode;
            state_d     = WAIT_VS;
          end
        end
      end
      WAIT_VS: begin
        if (vs_rise_q || tmo_hit) begin
          state_d    = HOLD;
          vg_reset_d = 1'b1;
        end
      end
      HOLD: begin
        state_d      = SETTLE;
        vg_reset_d   = 1'b1;
        cur_mode_d   = pend_mode_q;
        timing_d     = mode_entry(pend_mode_q);
        settle_cnt_d = '0;
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          vg_reset_d = 1'b0;
          lock_cnt_d = '0;
          state_d    = LOCK;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      LOCK: begin
        if (vs_rise_q && lock_cnt_q == LOCK_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (vs_rise_q) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timing_q     <= mode_entry(DEFAULT_MODE);
      cur_mode_q   <= DEFAULT_MODE;
      pend_mode_q  <= DEFAULT_MODE;
      settle_cnt_q <= '0;
      lock_cnt_q   <= '0;
      vs_sync_q    <= '0;
      vs_rise_q    <= 1'b0;
      vg_reset_q   <= 1'b1;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef VMC_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      timing_q     <= timing_d;
      cur_mode_q   <= cur_mode_d;
      pend_mode_q  <= pend_mode_d;
      settle_cnt_q <= settle_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      vs_sync_q    <= vs_sync_d;
      vs_rise_q    <= vs_rise_d;
      vg_reset_q   <= vg_reset_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef VMC_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.cur_mode    = cur_mode_q;
  assign bus.vg_reset    = vg_reset_q;
  assign bus.clk_sel     = timing_q.clk_sel;
  assign bus.interlaced  = timing_q.interlaced;
  assign bus.h_total     = timing_q.h_total;
  assign bus.h_fp        = timing_q.h_fp;
  assign bus.h_sync      = timing_q.h_sync;
  assign bus.h_bp        = timing_q.h_bp;
  assign bus.v_total_0   = timing_q.v_total_0;
  assign bus.v_fp_0      = timing_q.v_fp_0;
  assign bus.v_sync_0    = timing_q.v_sync_0;
  assign bus.v_bp_0      = timing_q.v_bp_0;
  assign bus.v_total_1   = timing_q.v_total_1;
  assign bus.v_fp_1      = timing_q.v_fp_1;
  assign bus.v_sync_1    = timing_q.v_sync_1;
  assign bus.v_bp_1      = timing_q.v_bp_1;
  assign bus.hv_offset_1 = timing_q.hv_offset_1;
  assign bus.ramp_step   = timing_q.ramp_step;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: directed vector table plus random requests, checked against
// a mode-table model and event timing derived from recorded vs_in rise times.
module tb_video_mode_ctrl;

  localparam int SETTLE  = 256;
  localparam int FRAMES  = 2;
  localparam int ACT_LAT = 4;
  localparam int BOUND   = 5000;

  typedef struct {
    int ht, hf, hs, hb;
    int vt0, vf0, vs0, vb0;
    int vt1, vf1, vs1, vb1;
    int hvo, il, cs, ramp;
  } mode_ref_t;

  typedef struct {
    int mode;
    bit hold;
    bit exp_err;
    int exp_ht;
    int exp_vt0;
    int exp_vt1;
    int exp_hvo;
    int exp_il;
    int exp_cs;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_mode = 2;
  int   vs_rises[$];
  mode_ref_t ref_tab[5];
  vec_t vecs[$];

  video_mode_ctrl_if bus();

  video_mode_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .LOCK_FRAMES   (FRAMES),
    .TIMEOUT_CYCLES(4000000),
    .DEFAULT_MODE  (3'd2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Free-running vsync, asynchronous in spirit: changes 2 ns after a clk edge.
  initial begin
    bus.vs_in = 1'b0;
    forever begin
      repeat ($urandom_range(400, 900)) @(posedge clk);
      #2 bus.vs_in = 1'b1;
      vs_rises.push_back(cyc);
      repeat (10) @(posedge clk);
      #2 bus.vs_in = 1'b0;
    end
  end

  // A vs_in rise becomes visible ACT_LAT cycles later; the k-th such reaction after edge t.
  function automatic int actAfter(input int t, input int k);
    int n;
    n = 0;
    foreach (vs_rises[i]) begin
      if (vs_rises[i] + ACT_LAT > t) begin
        n++;
        if (n == k) return vs_rises[i] + ACT_LAT;
      end
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic checkTable(input string tag, input int m);
    mode_ref_t r;
    r = ref_tab[m];
    checkOutput({tag, ".cur_mode"}, bus.cur_mode, m);
    checkOutput({tag, ".h_total"}, bus.h_total, r.ht);
    checkOutput({tag, ".h_fp"}, bus.h_fp, r.hf);
    checkOutput({tag, ".h_sync"}, bus.h_sync, r.hs);
    checkOutput({tag, ".h_bp"}, bus.h_bp, r.hb);
    checkOutput({tag, ".v_total_0"}, bus.v_total_0, r.vt0);
    checkOutput({tag, ".v_fp_0"}, bus.v_fp_0, r.vf0);
    checkOutput({tag, ".v_sync_0"}, bus.v_sync_0, r.vs0);
    checkOutput({tag, ".v_bp_0"}, bus.v_bp_0, r.vb0);
    checkOutput({tag, ".v_total_1"}, bus.v_total_1, r.vt1);
    checkOutput({tag, ".v_fp_1"}, bus.v_fp_1, r.vf1);
    checkOutput({tag, ".v_sync_1"}, bus.v_sync_1, r.vs1);
    checkOutput({tag, ".v_bp_1"}, bus.v_bp_1, r.vb1);
    checkOutput({tag, ".hv_offset_1"}, bus.hv_offset_1, r.hvo);
    checkOutput({tag, ".interlaced"}, bus.interlaced, r.il);
    checkOutput({tag, ".clk_sel"}, bus.clk_sel, r.cs);
    checkOutput({tag, ".ramp_step"}, bus.ramp_step, r.ramp);
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    checkOutput({tag, ".h_total"}, bus.h_total, v.exp_ht);
    checkOutput({tag, ".v_total_0"}, bus.v_total_0, v.exp_vt0);
    checkOutput({tag, ".v_total_1"}, bus.v_total_1, v.exp_vt1);
    checkOutput({tag, ".hv_offset_1"}, bus.hv_offset_1, v.exp_hvo);
    checkOutput({tag, ".interlaced"}, bus.interlaced, v.exp_il);
    checkOutput({tag, ".clk_sel"}, bus.clk_sel, v.exp_cs);
  endtask

  // Called at a negedge right after reset is dropped; returns at the negedge vg_reset is low.
  task automatic startupCheck(input string tag);
    int t0;
    int n;
    t0 = cyc;
    n = 0;
    while (bus.vg_reset && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".vg_reset_low"}, bus.vg_reset, 0);
    checkOutput({tag, ".settle_len"}, cyc - t0, SETTLE);
    checkOutput({tag, ".req_ready"}, bus.req_ready, 1);
    checkOutput({tag, ".busy"}, bus.busy, 0);
    checkTable(tag, 2);
  endtask

  task automatic applyStimulus(input vec_t v);
    int  n, t_xfer, t_hold, t_fall, t_done, old_mode;
    bit  ready_seen;
    old_mode = model_mode;
    n = 0;
    while (!bus.req_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pre.req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_mode  = 3'(v.mode);
    @(negedge clk);
    t_xfer = cyc;
    bus.req_valid = 1'b0;

    if (v.exp_err) begin
      checkOutput("inv.err", bus.err, 1);
      checkOutput("inv.busy", bus.busy, 0);
      checkOutput("inv.req_ready", bus.req_ready, 1);
      checkVector("inv.vec", v);
      checkTable("inv", old_mode);
      @(negedge clk);
      checkOutput("inv.err_pulse_len", bus.err, 0);
      checkOutput("inv.busy_after", bus.busy, 0);
      return;
    end

    checkOutput("xfer.busy", bus.busy, 1);
    checkOutput("xfer.req_ready", bus.req_ready, 0);
    checkOutput("xfer.err", bus.err, 0);
    n = 0;
    while (!bus.vg_reset && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    t_hold = cyc;
    checkOutput("hold.vg_reset", bus.vg_reset, 1);
    checkOutput("hold.time", t_hold, actAfter(t_xfer, 1));
    checkOutput("hold.cur_mode_old", bus.cur_mode, old_mode);
    checkOutput("hold.h_total_old", bus.h_total, ref_tab[old_mode].ht);

    @(negedge clk);
    checkTable("switch", v.mode);
    checkVector("switch.vec", v);
    checkOutput("switch.vg_reset", bus.vg_reset, 1);
    n = 2;
    while (bus.vg_reset && n < BOUND) begin
      @(negedge clk);
      if (bus.vg_reset) n++;
    end
    t_fall = cyc;
    checkOutput("settle.high_cycles", n, 1 + SETTLE);

    if (v.hold) begin
      bus.req_valid = 1'b1;
      bus.req_mode  = 3'((v.mode + 1) % 5);
    end
    ready_seen = 1'b0;
    n = 0;
    while (!bus.done && n < BOUND) begin
      @(negedge clk);
      n++;
      if (!bus.done && bus.req_ready) ready_seen = 1'b1;
    end
    t_done = cyc;
    bus.req_valid = 1'b0;
    checkOutput("lock.done_seen", bus.done, 1);
    checkOutput("lock.done_time", t_done, actAfter(t_fall, FRAMES));
    checkOutput("lock.ready_low", ready_seen, 0);
    checkOutput("done.req_ready", bus.req_ready, 1);
    checkOutput("done.busy", bus.busy, 0);
    checkOutput("done.vg_reset", bus.vg_reset, 0);
    checkTable("done", v.mode);

    @(negedge clk);
    checkOutput("done.pulse_len", bus.done, 0);
    checkOutput("idle.busy", bus.busy, 0);
    checkOutput("idle.cur_mode", bus.cur_mode, v.mode);
    model_mode = v.mode;
  endtask

  initial begin
    int n;
    int pred;
    vec_t rv;

    ref_tab[0] = '{1716, 110, 40, 220, 262, 5, 5, 20, 0, 0, 0, 0, 0, 0, 0, 'h333};
    ref_tab[1] = '{858, 16, 62, 60, 525, 9, 6, 30, 0, 0, 0, 0, 0, 0, 0, 'h333};
    ref_tab[2] = '{1650, 110, 40, 220, 750, 5, 5, 20, 0, 0, 0, 0, 0, 0, 1, 'h333};
    ref_tab[3] = '{2200, 88, 44, 148, 562, 2, 5, 15, 563, 2, 5, 16, 1100, 1, 1, 'h222};
    ref_tab[4] = '{2200, 88, 44, 148, 1125, 4, 5, 36, 0, 0, 0, 0, 0, 0, 2, 'h222};

    // mode, hold-in-lock, err, h_total, v_total_0, v_total_1, hv_offset_1, interlaced, clk_sel
    vecs.push_back('{4, 0, 0, 2200, 1125, 0, 0, 0, 2});
    vecs.push_back('{3, 0, 0, 2200, 562, 563, 1100, 1, 1});
    vecs.push_back('{1, 1, 0, 858, 525, 0, 0, 0, 0});
    vecs.push_back('{6, 0, 1, 858, 525, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 858, 525, 0, 0, 0, 0});
    vecs.push_back('{7, 0, 1, 858, 525, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1716, 262, 0, 0, 0, 0});
    vecs.push_back('{5, 0, 1, 1716, 262, 0, 0, 0, 0});
    vecs.push_back('{2, 0, 0, 1650, 750, 0, 0, 0, 1});
    pred = 2;
    for (int i = 0; i < 6; i++) begin
      rv.mode    = int'($urandom_range(0, 7));
      rv.hold    = 1'($urandom_range(0, 1));
      rv.exp_err = (rv.mode > 4);
      if (!rv.exp_err) pred = rv.mode;
      rv.exp_ht  = ref_tab[pred].ht;
      rv.exp_vt0 = ref_tab[pred].vt0;
      rv.exp_vt1 = ref_tab[pred].vt1;
      rv.exp_hvo = ref_tab[pred].hvo;
      rv.exp_il  = ref_tab[pred].il;
      rv.exp_cs  = ref_tab[pred].cs;
      vecs.push_back(rv);
    end

    bus.req_valid = 1'b0;
    bus.req_mode  = 3'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst.vg_reset", bus.vg_reset, 1);
    checkOutput("rst.done", bus.done, 0);
    checkOutput("rst.err", bus.err, 0);
    checkOutput("rst.busy", bus.busy, 0);
    checkOutput("rst.req_ready", bus.req_ready, 1);
    checkTable("rst", 2);
    reset = 1'b0;
    startupCheck("startup");

    foreach (vecs[i]) begin
      $display("[TB] vector %0d: mode %0d hold %0d", i, vecs[i].mode, vecs[i].hold);
      applyStimulus(vecs[i]);
      checkOutput("model.cur_mode", bus.cur_mode, model_mode);
    end

    // Reset in the middle of a 1080p switch must abandon it and restore the default mode.
    bus.req_valid = 1'b1;
    bus.req_mode  = 3'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.vg_reset && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checkOutput("midrst.busy_before", bus.busy, 1);
    checkOutput("midrst.cur_mode_before", bus.cur_mode, 4);
    reset = 1'b1;
    #1;
    checkOutput("midrst.busy", bus.busy, 0);
    checkOutput("midrst.req_ready", bus.req_ready, 1);
    checkOutput("midrst.vg_reset", bus.vg_reset, 1);
    checkTable("midrst", 2);
    @(negedge clk);
    reset = 1'b0;
    startupCheck("midrst.release");
    model_mode = 2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
